// File: rtl/pipeline_pkg.sv
// Shared fetch/decode pipeline definitions: the NOP encoding, the word width,
// and the {pc, instr} pair type.
package pipeline_pkg;

    localparam int WORD_W = 32;

    // The all-zero word is the MIPS NOP (sll $0, $0, 0).
    localparam logic [WORD_W-1:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_pair_t;

endpackage

// File: rtl/if_id_queue_if.sv
// Fetch-to-decode queue bus: fetch-side handshake, flush, decode-side handshake
// and the occupancy count.
interface if_id_queue_if #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_pc;
    logic [WIDTH-1:0] out_instr;
    logic [CNT_W-1:0] count;

    // The master modport represents the surrounding pipeline (fetch + decode).
    modport master (
        output in_valid, in_pc, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, count
    );

    modport slave (
        input  in_valid, in_pc, in_instr, flush, out_ready,
        output in_ready, out_valid, out_pc, out_instr, count
    );

endinterface

// File: rtl/if_id_queue_storage.sv
// DEPTH-entry register array for the instruction queue: one synchronous write
// port, one asynchronous read port, cleared by the asynchronous reset.
module queue_storage #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is reset, unlike a RAM, so out_pc reads 0 while rst is low;
    // every state update uses <= so all entries see the same pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {pc, instr} pairs with a
// valid/ready handshake on each side, a flush, and a NOP on out_instr when empty.
module if_id_queue
    import pipeline_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = WORD_W
) (
    input logic          clk,
    input logic          rst,
    if_id_queue_if.slave q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [2*WIDTH-1:0] head;

    // Ready and valid depend only on registered occupancy, so there is no path
    // from out_ready to in_ready and a full queue never writes through.
    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign push  = q.in_valid & ~full;
    assign pop   = q.out_ready & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (q.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so they wrap on their own.
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    queue_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (2 * WIDTH)
    ) u_storage (
        .clk   (clk),
        .rst   (rst),
        .we    (push & ~q.flush),
        .waddr (wr_ptr),
        .wdata ({q.in_pc, q.in_instr}),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign q.in_ready  = ~full;
    assign q.out_valid = ~empty;
    assign q.count     = count_q;
    assign q.out_pc    = head[2*WIDTH-1:WIDTH];
    assign q.out_instr = empty ? WIDTH'(NOP) : head[WIDTH-1:0];

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: DEPTH=2 and DEPTH=4 instances share one stimulus stream;
// each is scored against its own queue-of-pairs model of the FIFO rules.
module tb_if_id_queue;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_ready;

    int n_checks = 0;
    int n_errors = 0;
    int pops2    = 0;
    int pops4    = 0;

    fetch_pair_t m2[$];
    fetch_pair_t m4[$];

    if_id_queue_if #(.DEPTH(2), .WIDTH(32)) q2 ();
    if_id_queue_if #(.DEPTH(4), .WIDTH(32)) q4 ();

    assign q2.in_valid  = in_valid;
    assign q2.in_pc     = in_pc;
    assign q2.in_instr  = in_instr;
    assign q2.flush     = flush;
    assign q2.out_ready = out_ready;
    assign q4.in_valid  = in_valid;
    assign q4.in_pc     = in_pc;
    assign q4.in_instr  = in_instr;
    assign q4.flush     = flush;
    assign q4.out_ready = out_ready;

    if_id_queue #(.DEPTH(2), .WIDTH(32)) dut2 (.clk(clk), .rst(rst), .q(q2.slave));
    if_id_queue #(.DEPTH(4), .WIDTH(32)) dut4 (.clk(clk), .rst(rst), .q(q4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a FIFO of pairs; acceptance and delivery follow occupancy.
    function automatic void model_edge(inout fetch_pair_t m[$], input int depth, inout int pops);
        bit do_push = in_valid && (m.size() != depth);
        bit do_pop  = out_ready && (m.size() != 0);
        if (do_pop) begin
            void'(m.pop_front());
            pops++;
        end
        if (do_push) m.push_back('{pc: in_pc, instr: in_instr});
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst || flush) begin
            m2.delete();
            m4.delete();
        end else begin
            model_edge(m2, 2, pops2);
            model_edge(m4, 4, pops4);
        end
    end

    task automatic check_bus(input string tag, input int depth, input fetch_pair_t m[$],
                             input logic ov, input logic ir, input logic [2:0] cnt,
                             input logic [31:0] opc, input logic [31:0] oin);
        check({tag, ".count"}, 64'(cnt), 64'(m.size()));
        check({tag, ".count_le_depth"}, 64'(int'(cnt) <= depth), 64'd1);
        check({tag, ".out_valid"}, 64'(ov), 64'(m.size() != 0));
        check({tag, ".in_ready"}, 64'(ir), 64'(m.size() != depth));
        if (m.size() != 0) begin
            check({tag, ".head_pc"}, 64'(opc), 64'(m[0].pc));
            check({tag, ".head_instr"}, 64'(oin), 64'(m[0].instr));
        end else begin
            check({tag, ".empty_nop"}, 64'(oin), 64'(NOP));
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            check_bus("d2", 2, m2, q2.out_valid, q2.in_ready, 3'(q2.count), q2.out_pc, q2.out_instr);
            check_bus("d4", 4, m4, q4.out_valid, q4.in_ready, 3'(q4.count), q4.out_pc, q4.out_instr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy);
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = rdy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sent;
        int          pops_start;
        bit          holding;
        bit          acc;
        logic        v;
        logic [31:0] pc;

        rst = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        step();
        check("reset.out_valid", 64'(q2.out_valid), 64'd0);
        check("reset.in_ready", 64'(q2.in_ready), 64'd1);
        check("reset.out_instr", 64'(q2.out_instr), 64'(NOP));
        check("reset.out_pc", 64'(q2.out_pc), 64'd0);
        step();
        rst = 1'b1;

        // Fill and stall: the third pair is held off by in_ready.
        drive(1'b1, 32'h00, 1'b0); step();
        drive(1'b1, 32'h04, 1'b0); step();
        drive(1'b1, 32'h08, 1'b0); step();
        check("fill.count", 64'(q2.count), 64'd2);
        check("fill.in_ready", 64'(q2.in_ready), 64'd0);
        check("fill.out_pc", 64'(q2.out_pc), 64'h00);
        step();
        check("stall.count", 64'(q2.count), 64'd2);
        check("stall.out_pc", 64'(q2.out_pc), 64'h00);

        // Mid-cycle asynchronous reset with entries held.
        #2 rst = 1'b0;
        #1;
        check("midrst.out_valid", 64'(q2.out_valid), 64'd0);
        check("midrst.in_ready", 64'(q2.in_ready), 64'd1);
        check("midrst.count", 64'(q2.count), 64'd0);
        check("midrst.out_instr", 64'(q2.out_instr), 64'(NOP));
        drive(1'b0, 32'h0, 1'b0);
        step();
        rst = 1'b1;

        // Simultaneous push and pop at count=1 through 8 pointer wraps.
        drive(1'b1, 32'h10, 1'b0); step();
        check("pp.init_count", 64'(q2.count), 64'd1);
        check("pp.init_pc", 64'(q2.out_pc), 64'h10);
        for (int k = 1; k <= 16; k++) begin
            drive(1'b1, 32'h10 + 32'(4 * k), 1'b1);
            step();
            check("pp.count", 64'(q2.count), 64'd1);
            check("pp.head_pc", 64'(q2.out_pc), 64'(32'h10 + 32'(4 * k)));
        end

        // Flush beats a same-cycle push and pop.
        drive(1'b1, 32'h100, 1'b0); step();
        check("flush.pre_count", 64'(q2.count), 64'd2);
        drive(1'b1, 32'h40, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush.count", 64'(q2.count), 64'd0);
        check("flush.out_valid", 64'(q2.out_valid), 64'd0);
        check("flush.out_instr", 64'(q2.out_instr), 64'(NOP));
        check("flush.in_ready", 64'(q2.in_ready), 64'd1);
        drive(1'b0, 32'h0, 1'b0); step();
        check("flush.stays_empty", 64'(q2.out_valid), 64'd0);

        // DEPTH=4: in_ready drops exactly at 4, out_valid after the 4th pop.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b0);
            step();
            check("d4fill.count", 64'(q4.count), 64'(i));
            check("d4fill.in_ready", 64'(q4.in_ready), 64'(i != 4));
        end
        drive(1'b0, 32'h0, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            step();
            check("d4drain.count", 64'(q4.count), 64'(4 - j));
            check("d4drain.out_valid", 64'(q4.out_valid), 64'(j != 4));
        end
        flush = 1'b1; drive(1'b0, 32'h0, 1'b0); step(); flush = 1'b0;

        // Random streaming, driver honours the hold-while-stalled rule of dut2.
        pc = 32'h1000;
        sent = 0;
        holding = 1'b0;
        pops_start = pops2;
        for (int cyc = 0; cyc < 3000 && sent < 100; cyc++) begin
            v = holding ? 1'b1 : 1'($urandom_range(0, 1));
            drive(v, pc, 1'($urandom_range(0, 1)));
            acc = in_valid && q2.in_ready;
            step();
            if (acc) begin
                sent++;
                pc = pc + 32'd4;
                holding = 1'b0;
            end else begin
                holding = v;
            end
        end
        drive(1'b0, 32'h0, 1'b1);
        repeat (10) step();
        check("stream.sent", 64'(sent), 64'd100);
        check("stream.delivered", 64'(pops2 - pops_start), 64'd100);
        check("stream.final_count", 64'(q2.count), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
